// File: rtl/cas_pkg.sv
// Cassette constants shared by recorder and player: FSM states, leader byte, default tick periods.
// Definitions only; no logic, no latency, no flow control.
package cas_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HUNT = 2'd1,
        DATA = 2'd2
    } cas_state_t;

    localparam logic [7:0] LEADER_BYTE  = 8'h55;
    localparam int         CLK_DIV_DEF  = 57;
    localparam int         P_MIN_DEF    = 250;
    localparam int         P_THRESH_DEF = 625;
    localparam int         P_MAX_DEF    = 1200;
    localparam int         DEB_DEF      = 3;
endpackage

// File: rtl/cas_edge_timer.sv
// Synchronises and debounces cas_in, times rising-edge periods in 1 us ticks, classifies each cycle.
// Pulses are combinational in the tick that accepts the edge; no backpressure (pulses are not held).
module cas_edge_timer
    import cas_pkg::*;
#(
    parameter int CLK_DIV  = CLK_DIV_DEF,
    parameter int P_MIN    = P_MIN_DEF,
    parameter int P_THRESH = P_THRESH_DEF,
    parameter int P_MAX    = P_MAX_DEF,
    parameter int DEB      = DEB_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic cas_in,
    output logic bit_valid,
    output logic bit_val,
    output logic dropout
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DEB_W = $clog2(DEB + 1);
    localparam int PER_W = $clog2(P_MAX + 3);

    logic             sync1, sync2, level, tick, accept, rise, armed;
    logic [DIV_W-1:0] div_cnt;
    logic [DEB_W-1:0] deb_cnt;
    logic [PER_W-1:0] per_cnt, elapsed;

    assign tick    = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign accept  = tick && (sync2 != level) && (deb_cnt == DEB_W'(DEB - 1));
    assign rise    = accept && sync2;
    assign elapsed = per_cnt + PER_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            div_cnt <= '0;
            level   <= 1'b0;
            deb_cnt <= '0;
        end else begin
            sync1   <= cas_in;
            sync2   <= sync1;
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            if (tick) begin
                if (sync2 == level || accept) begin
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + DEB_W'(1);
                end
                if (accept) begin
                    level <= sync2;
                end
            end
        end
    end

    // per_cnt holds ticks since the last accepted rise and parks at P_MAX+1
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            per_cnt <= '0;
            armed   <= 1'b0;
        end else if (clr) begin
            per_cnt <= '0;
            armed   <= 1'b0;
        end else if (rise) begin
            per_cnt <= '0;
            armed   <= 1'b1;
        end else if (tick && per_cnt <= PER_W'(P_MAX)) begin
            per_cnt <= elapsed;
        end
    end

    assign bit_val   = (elapsed < PER_W'(P_THRESH));
    assign bit_valid = !clr && armed && rise &&
                       (elapsed >= PER_W'(P_MIN)) && (elapsed <= PER_W'(P_MAX));
    assign dropout   = !clr && ((armed && rise && elapsed > PER_W'(P_MAX)) ||
                                (tick && !rise && per_cnt == PER_W'(P_MAX)));
endmodule

// File: rtl/cassette_recorder.sv
// Decodes FSK cassette bits, aligns on the 0x55 leader and writes CAS bytes sequentially to SRAM.
// ram_wr one clk after the completing edge, address advances the clk after; no backpressure, SRAM must accept.
module cassette_recorder
    import cas_pkg::*;
#(
    parameter int CLK_DIV  = CLK_DIV_DEF,
    parameter int P_MIN    = P_MIN_DEF,
    parameter int P_THRESH = P_THRESH_DEF,
    parameter int P_MAX    = P_MAX_DEF,
    parameter int DEB      = DEB_DEF,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              rewind,
    input  logic              cas_in,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_data,
    output logic              ram_wr,
    output logic [ADDR_W:0]   byte_count,
    output logic              full,
    output logic              recording
);
    cas_state_t state, state_nxt;
    logic [7:0] sr, sr_nxt, sr_shift;
    logic [2:0] bitcnt, bitcnt_nxt;
    logic [3:0] seen, seen_nxt, seen_inc;
    logic       bit_valid, bit_val, dropout, wr_req, wr_q;

    cas_edge_timer #(
        .CLK_DIV  (CLK_DIV),
        .P_MIN    (P_MIN),
        .P_THRESH (P_THRESH),
        .P_MAX    (P_MAX),
        .DEB      (DEB)
    ) u_edge_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr       (state == IDLE),
        .cas_in    (cas_in),
        .bit_valid (bit_valid),
        .bit_val   (bit_val),
        .dropout   (dropout)
    );

    assign sr_shift = {bit_val, sr[7:1]};
    assign seen_inc = (seen == 4'd8) ? seen : seen + 4'd1;

    always_comb begin
        state_nxt  = state;
        sr_nxt     = sr;
        bitcnt_nxt = bitcnt;
        seen_nxt   = seen;
        wr_req     = 1'b0;
        if (!en) begin
            state_nxt  = IDLE;
            sr_nxt     = '0;
            bitcnt_nxt = '0;
            seen_nxt   = '0;
        end else if (state == IDLE) begin
            state_nxt = HUNT;
        end else if (dropout) begin
            state_nxt  = HUNT;
            sr_nxt     = '0;
            bitcnt_nxt = '0;
            seen_nxt   = '0;
        end else if (bit_valid) begin
            sr_nxt = sr_shift;
            if (state == HUNT) begin
                seen_nxt = seen_inc;
                // seen_inc counts the bit just shifted in, so a clean leader locks on its 8th bit
                if (sr_shift == LEADER_BYTE && seen_inc == 4'd8) begin
                    wr_req     = 1'b1;
                    bitcnt_nxt = '0;
                    state_nxt  = DATA;
                end
            end else begin
                bitcnt_nxt = bitcnt + 3'd1;
                wr_req     = (bitcnt == 3'd7);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            sr     <= '0;
            bitcnt <= '0;
            seen   <= '0;
        end else begin
            state  <= state_nxt;
            sr     <= sr_nxt;
            bitcnt <= bitcnt_nxt;
            seen   <= seen_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q       <= 1'b0;
            ram_data   <= '0;
            ram_addr   <= '0;
            byte_count <= '0;
            full       <= 1'b0;
        end else begin
            wr_q <= wr_req && !full && !rewind;
            if (wr_req && !full && !rewind) begin
                ram_data <= sr_shift;
            end
            if (rewind) begin
                ram_addr   <= '0;
                byte_count <= '0;
                full       <= 1'b0;
            end else if (wr_q) begin
                byte_count <= byte_count + (ADDR_W + 1)'(1);
                if (&ram_addr) begin
                    full <= 1'b1;
                end else begin
                    ram_addr <= ram_addr + ADDR_W'(1);
                end
            end
        end
    end

    assign ram_wr    = wr_q && !rewind;
    assign recording = (state == DATA);
endmodule

// File: tb/tb_cassette_recorder.sv
// Bench for cassette_recorder with tick periods scaled down 10x and a 16-entry SRAM.
// Random FSK streams are scored against a leader-search/byte-chunking reference model.
module tb_cassette_recorder;
    localparam int CLK_DIV = 2, P_MIN = 25, P_THRESH = 62, P_MAX = 120, DEB = 3, ADDR_W = 4;

    logic              clk = 1'b0, reset_n = 1'b0, en = 1'b0, rewind = 1'b0, cas_in = 1'b0;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_data;
    logic              ram_wr, full, recording;
    logic [ADDR_W:0]   byte_count;
    logic [19:0]       outs;

    int total = 0, bad = 0;

    always #5 clk = ~clk;

    cassette_recorder #(
        .CLK_DIV(CLK_DIV), .P_MIN(P_MIN), .P_THRESH(P_THRESH),
        .P_MAX(P_MAX), .DEB(DEB), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .rewind(rewind), .cas_in(cas_in),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_wr(ram_wr),
        .byte_count(byte_count), .full(full), .recording(recording)
    );

    assign outs = {ram_addr, ram_data, ram_wr, byte_count, full, recording};

    int act_addr[$], act_data[$], exp_addr[$], exp_data[$];
    bit act_rec[$];
    bit wr_prev = 1'b0;
    int wr_long = 0;

    always @(negedge clk) begin
        if (ram_wr) begin
            act_addr.push_back(int'(ram_addr));
            act_data.push_back(int'(ram_data));
            act_rec.push_back(recording);
        end
        if (ram_wr && wr_prev) wr_long++;
        wr_prev = ram_wr;
    end

    // reference model: SRAM pointer plus leader search over a segment's decoded bits
    int m_addr = 0, m_cnt = 0;
    bit m_full = 1'b0;
    bit tx_bits[$];
    int snap_addr, snap_cnt, snap_full;

    task automatic clear_queues();
        act_addr.delete(); act_data.delete(); act_rec.delete();
        exp_addr.delete(); exp_data.delete();
    endtask

    task automatic model_write(input int d, input bit rw);
        if (rw) begin
            m_addr = 0; m_cnt = 0; m_full = 1'b0;
        end else if (!m_full) begin
            exp_addr.push_back(m_addr);
            exp_data.push_back(d);
            m_cnt++;
            if (m_addr == (1 << ADDR_W) - 1) m_full = 1'b1;
            else m_addr++;
        end
    endtask

    function automatic int pack_at(input int i);
        int v = 0;
        for (int k = 0; k < 8; k++) v |= int'(tx_bits[i+k]) << k;
        return v;
    endfunction

    task automatic model_seg(input int rw_bit);
        int sync = -1;
        for (int i = 7; i < tx_bits.size(); i++)
            if (sync < 0 && pack_at(i - 7) == 8'h55) sync = i;
        if (sync >= 0) begin
            model_write(8'h55, sync == rw_bit);
            for (int j = sync + 1; j + 7 < tx_bits.size(); j += 8)
                model_write(pack_at(j), (j + 7) == rw_bit);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int k = 0; k < 8; k++) tx_bits.push_back(b[k]);
    endtask

    task automatic wait_ticks(input int n);
        repeat (n * CLK_DIV) @(negedge clk);
    endtask

    // each cycle is high then low; its bit is decoded at the next cycle's rise
    task automatic send_cycles(input int rw_bit, input bit noisy);
        int per, hi, lo;
        for (int i = 0; i < tx_bits.size(); i++) begin
            per = tx_bits[i] ? int'($urandom_range(32, 48)) : int'($urandom_range(72, 100));
            hi  = per / 2;
            lo  = per - hi;
            if (noisy && (i % 3 == 2)) begin
                cas_in = 1'b1; wait_ticks(5); cas_in = 1'b0; wait_ticks(5);
            end
            cas_in = 1'b1;
            if (i == rw_bit + 1) begin
                wait_ticks(hi / 2);
                snap_addr = int'(ram_addr); snap_cnt = int'(byte_count); snap_full = int'(full);
                rewind = 1'b0;
                wait_ticks(hi - hi / 2);
            end else begin
                wait_ticks(hi);
            end
            cas_in = 1'b0;
            if (noisy && (i % 3 == 1)) begin
                wait_ticks(lo / 2); cas_in = 1'b1; wait_ticks(1); cas_in = 1'b0; wait_ticks(lo - lo / 2 - 1);
            end else if (i == rw_bit) begin
                wait_ticks(lo / 2); rewind = 1'b1; wait_ticks(lo - lo / 2);
            end else begin
                wait_ticks(lo);
            end
        end
    endtask

    task automatic end_seg();
        cas_in = 1'b1; wait_ticks(20);
        cas_in = 1'b0; wait_ticks(200);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; en = 1'b0; rewind = 1'b0; cas_in = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (outs !== 20'd0) begin bad++; $display("FAIL reset_hold: outputs got %h want 0", outs); end
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if (outs !== 20'd0) begin bad++; $display("FAIL reset_release: outputs got %h want 0", outs); end
    endtask

    task automatic test_basic();
        clear_queues(); tx_bits.delete();
        en = 1'b1;
        push_byte(8'h55); push_byte(8'h55); push_byte(8'h3C);
        model_seg(-1);
        send_cycles(-1, 1'b0); end_seg();
        total++;
        if (act_addr.size() != exp_addr.size()) begin bad++; $display("FAIL basic_nwr: got %0d want %0d", act_addr.size(), exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < act_addr.size(); i++) begin
            total++;
            if (act_addr[i] != exp_addr[i] || act_data[i] != exp_data[i]) begin
                bad++; $display("FAIL basic_wr%0d: got %0d/%h want %0d/%h", i, act_addr[i], act_data[i], exp_addr[i], exp_data[i]);
            end
        end
        total++;
        if (act_rec.size() == 0 || act_rec[0] !== 1'b1) begin bad++; $display("FAIL basic_recording: got %0d writes/rec want rec=1", act_rec.size()); end
        total++;
        if (byte_count !== (ADDR_W+1)'(m_cnt)) begin bad++; $display("FAIL basic_count: got %0d want %0d", byte_count, m_cnt); end
        total++;
        if (wr_long != 0) begin bad++; $display("FAIL basic_strobe_len: got %0d long strobes want 0", wr_long); end
    endtask

    task automatic test_gap();
        clear_queues(); tx_bits.delete();
        push_byte(8'h55); push_byte(8'h55);
        for (int k = 0; k < 4; k++) tx_bits.push_back(1'($urandom_range(0, 1)));
        model_seg(-1);
        send_cycles(-1, 1'b0); end_seg();
        total++;
        if (recording !== 1'b0) begin bad++; $display("FAIL gap_hunt: recording got %b want 0", recording); end
        tx_bits.delete();
        push_byte(8'h55); push_byte(8'($urandom));
        model_seg(-1);
        send_cycles(-1, 1'b0); end_seg();
        total++;
        if (act_addr.size() != exp_addr.size()) begin bad++; $display("FAIL gap_nwr: got %0d want %0d", act_addr.size(), exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < act_addr.size(); i++) begin
            total++;
            if (act_addr[i] != exp_addr[i] || act_data[i] != exp_data[i]) begin
                bad++; $display("FAIL gap_wr%0d: got %0d/%h want %0d/%h", i, act_addr[i], act_data[i], exp_addr[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_glitch();
        clear_queues(); tx_bits.delete();
        push_byte(8'h55);
        for (int k = 0; k < 3; k++) push_byte(8'($urandom));
        model_seg(-1);
        send_cycles(-1, 1'b1); end_seg();
        total++;
        if (act_addr.size() != exp_addr.size()) begin bad++; $display("FAIL glitch_nwr: got %0d want %0d", act_addr.size(), exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < act_addr.size(); i++) begin
            total++;
            if (act_addr[i] != exp_addr[i] || act_data[i] != exp_data[i]) begin
                bad++; $display("FAIL glitch_wr%0d: got %0d/%h want %0d/%h", i, act_addr[i], act_data[i], exp_addr[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_rewind();
        clear_queues(); tx_bits.delete();
        for (int k = 0; k < 3; k++) push_byte(k == 0 ? 8'h55 : 8'($urandom));
        push_byte(8'($urandom));
        model_seg(23);
        send_cycles(23, 1'b0); end_seg();
        total++;
        if (snap_addr != 0 || snap_cnt != 0 || snap_full != 0) begin
            bad++; $display("FAIL rewind_clear: got addr=%0d cnt=%0d full=%0d want 0/0/0", snap_addr, snap_cnt, snap_full);
        end
        total++;
        if (act_addr.size() != exp_addr.size()) begin bad++; $display("FAIL rewind_nwr: got %0d want %0d", act_addr.size(), exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < act_addr.size(); i++) begin
            total++;
            if (act_addr[i] != exp_addr[i] || act_data[i] != exp_data[i]) begin
                bad++; $display("FAIL rewind_wr%0d: got %0d/%h want %0d/%h", i, act_addr[i], act_data[i], exp_addr[i], exp_data[i]);
            end
        end
        total++;
        if (byte_count !== (ADDR_W+1)'(m_cnt)) begin bad++; $display("FAIL rewind_count: got %0d want %0d", byte_count, m_cnt); end
    endtask

    task automatic test_en_drop();
        clear_queues(); tx_bits.delete();
        push_byte(8'h55); push_byte(8'h55); push_byte(8'($urandom));
        for (int k = 0; k < 4; k++) tx_bits.push_back(1'($urandom_range(0, 1)));
        model_seg(-1);
        send_cycles(-1, 1'b0);
        en = 1'b0;
        wait_ticks(10);
        total++;
        if (recording !== 1'b0 || ram_addr !== ADDR_W'(m_addr)) begin
            bad++; $display("FAIL en_idle: got rec=%b addr=%0d want rec=0 addr=%0d", recording, ram_addr, m_addr);
        end
        en = 1'b1;
        wait_ticks(10);
        tx_bits.delete();
        push_byte(8'h55); push_byte(8'($urandom));
        model_seg(-1);
        send_cycles(-1, 1'b0); end_seg();
        total++;
        if (act_addr.size() != exp_addr.size()) begin bad++; $display("FAIL en_nwr: got %0d want %0d", act_addr.size(), exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < act_addr.size(); i++) begin
            total++;
            if (act_addr[i] != exp_addr[i] || act_data[i] != exp_data[i]) begin
                bad++; $display("FAIL en_wr%0d: got %0d/%h want %0d/%h", i, act_addr[i], act_data[i], exp_addr[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_full();
        clear_queues(); tx_bits.delete();
        rewind = 1'b1; wait_ticks(2); rewind = 1'b0;
        model_write(0, 1'b1);
        push_byte(8'h55);
        for (int k = 0; k < 20; k++) push_byte(8'($urandom));
        model_seg(-1);
        send_cycles(-1, 1'b0); end_seg();
        total++;
        if (act_addr.size() != 16) begin bad++; $display("FAIL full_nwr: got %0d want 16", act_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < act_addr.size(); i++) begin
            total++;
            if (act_addr[i] != exp_addr[i] || act_data[i] != exp_data[i]) begin
                bad++; $display("FAIL full_wr%0d: got %0d/%h want %0d/%h", i, act_addr[i], act_data[i], exp_addr[i], exp_data[i]);
            end
        end
        total++;
        if (full !== 1'b1 || ram_addr !== ADDR_W'(15) || byte_count !== (ADDR_W+1)'(16)) begin
            bad++; $display("FAIL full_state: got full=%b addr=%0d cnt=%0d want 1/15/16", full, ram_addr, byte_count);
        end
    endtask

    task automatic test_async_reset();
        tx_bits.delete();
        rewind = 1'b1; wait_ticks(2); rewind = 1'b0;
        push_byte(8'h55); push_byte(8'hA5);
        for (int k = 0; k < 4; k++) tx_bits.push_back(1'($urandom_range(0, 1)));
        send_cycles(-1, 1'b0);
        total++;
        if (recording !== 1'b1 || ram_addr !== ADDR_W'(2)) begin
            bad++; $display("FAIL areset_pre: got rec=%b addr=%0d want rec=1 addr=2", recording, ram_addr);
        end
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (outs !== 20'd0) begin bad++; $display("FAIL areset_immediate: outputs got %h want 0", outs); end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (outs !== 20'd0) begin bad++; $display("FAIL areset_after: outputs got %h want 0", outs); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gap();
        test_glitch();
        test_rewind();
        test_en_drop();
        test_full();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
